// File: rtl/line_sensor_pkg.sv
// Shared types and constants for the line-sensor processing block.
package line_sensor_pkg;

   localparam int unsigned SAMPLE_W = 12;
   localparam int unsigned STEER_W  = 3;
   localparam int unsigned LINE_W   = 3;
   localparam int unsigned DEB_W    = 3;
   localparam int unsigned CNT_W    = 8;

   typedef logic [SAMPLE_W-1:0]       sample_t;
   typedef logic signed [STEER_W-1:0] steer_t;

   typedef enum logic [1:0] {
      FOLLOW = 2'd0,
      NODE   = 2'd1,
      LOST   = 2'd2
   } lsp_state_e;

   localparam steer_t STEER_L2  = -3'sd2;
   localparam steer_t STEER_L1  = -3'sd1;
   localparam steer_t STEER_CTR = 3'sd0;
   localparam steer_t STEER_R1  = 3'sd1;
   localparam steer_t STEER_R2  = 3'sd2;

   // Map {L,C,R} to a signed steering error; all-white keeps the last value.
   function automatic steer_t steer_map(input logic [LINE_W-1:0] bits, input steer_t prev);
      steer_t res;
      case (bits)
         3'b010:  res = STEER_CTR;
         3'b110:  res = STEER_L1;
         3'b100:  res = STEER_L2;
         3'b011:  res = STEER_R1;
         3'b001:  res = STEER_R2;
         3'b000:  res = prev;
         default: res = STEER_CTR;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lsp_chan_filter.sv
// One sensor channel: stage 1 smoothing, stage 2 black/white hysteresis.
// LSP_AVG_EN defined: 4-sample moving average; undefined: raw sample register.
module lsp_chan_filter
   import line_sensor_pkg::*;
#(
   parameter sample_t TH_HI = 12'd1800,
   parameter sample_t TH_LO = 12'd1500
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  logic    s1_en_i,
   input  logic    s2_en_i,
   input  sample_t sample_i,
   output logic    bit_nxt_c,
   output logic    bit_o
);

   sample_t avg;
   logic    bit_q;

`ifdef LSP_AVG_EN
   localparam int unsigned SUM_W = SAMPLE_W + 2;

   sample_t            hist_q [4];
   logic [SUM_W-1:0]   sum_q;
   logic [SUM_W-1:0]   sum_d;

   // Running sum swaps the oldest history entry for the new sample.
   always_comb begin
      sum_d = sum_q + SUM_W'(sample_i) - SUM_W'(hist_q[3]);
   end

   // History shift register and running sum.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 4; i++) hist_q[i] <= '0;
         sum_q <= '0;
      end else if (s1_en_i) begin
         for (int i = 3; i > 0; i--) hist_q[i] <= hist_q[i-1];
         hist_q[0] <= sample_i;
         sum_q     <= sum_d;
      end
   end

   assign avg = sum_q[SUM_W-1:2];
`else
   sample_t raw_q;

   // Register the raw sample so latency matches the averaging build.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         raw_q <= '0;
      end else if (s1_en_i) begin
         raw_q <= sample_i;
      end
   end

   assign avg = raw_q;
`endif

   // Hysteresis: set at or above TH_HI, clear below TH_LO, otherwise hold.
   always_comb begin
      bit_nxt_c = bit_q;
      if (s2_en_i) begin
         if (avg >= TH_HI) begin
            bit_nxt_c = 1'b1;
         end else if (avg < TH_LO) begin
            bit_nxt_c = 1'b0;
         end
      end
   end

   // Classified bit register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bit_q <= 1'b0;
      end else begin
         bit_q <= bit_nxt_c;
      end
   end

   assign bit_o = bit_q;

endmodule

// File: rtl/line_sensor_proc.sv
// Three-channel line sensor processing: filtering, steering error, node/lost FSM.
// LSP_AVG_EN selects the moving-average front end in lsp_chan_filter.
module line_sensor_proc
   import line_sensor_pkg::*;
#(
   parameter sample_t     TH_HI    = 12'd1800,
   parameter sample_t     TH_LO    = 12'd1500,
   parameter int unsigned NODE_DEB = 3,
   parameter int unsigned LOST_DEB = 4
) (
   input  logic                      clk_50M,
   input  logic                      reset,
   input  logic                      sample_valid,
   input  logic [SAMPLE_W-1:0]       d_out_ch1,
   input  logic [SAMPLE_W-1:0]       d_out_ch3,
   input  logic [SAMPLE_W-1:0]       d_out_ch4,
   input  logic                      node_clr,
   output logic                      out_valid,
   output logic [LINE_W-1:0]         line_bits,
   output logic signed [STEER_W-1:0] steer_err,
   output logic                      node_pulse,
   output logic [CNT_W-1:0]          node_count,
   output logic                      line_lost
);

   logic              s1_valid_q;
   logic [LINE_W-1:0] bits_nxt_c;
   lsp_state_e        state_q, state_d;
   logic [DEB_W-1:0]  node_deb_q, node_deb_d;
   logic [DEB_W-1:0]  lost_deb_q, lost_deb_d;
   steer_t            steer_q, steer_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              out_valid_q;
   logic              node_pulse_q, node_pulse_d;

   lsp_chan_filter #(.TH_HI(TH_HI), .TH_LO(TH_LO)) u_ch1 (
      .clk_i(clk_50M), .rst_i(reset), .s1_en_i(sample_valid), .s2_en_i(s1_valid_q),
      .sample_i(d_out_ch1), .bit_nxt_c(bits_nxt_c[2]), .bit_o(line_bits[2])
   );

   lsp_chan_filter #(.TH_HI(TH_HI), .TH_LO(TH_LO)) u_ch3 (
      .clk_i(clk_50M), .rst_i(reset), .s1_en_i(sample_valid), .s2_en_i(s1_valid_q),
      .sample_i(d_out_ch3), .bit_nxt_c(bits_nxt_c[1]), .bit_o(line_bits[1])
   );

   lsp_chan_filter #(.TH_HI(TH_HI), .TH_LO(TH_LO)) u_ch4 (
      .clk_i(clk_50M), .rst_i(reset), .s1_en_i(sample_valid), .s2_en_i(s1_valid_q),
      .sample_i(d_out_ch4), .bit_nxt_c(bits_nxt_c[0]), .bit_o(line_bits[0])
   );

   // Stage-2 decisions: steering, node/lost FSM with debounce, node counter.
   always_comb begin
      state_d      = state_q;
      node_deb_d   = node_deb_q;
      lost_deb_d   = lost_deb_q;
      steer_d      = steer_q;
      node_pulse_d = 1'b0;
      count_d      = count_q;

      if (s1_valid_q) begin
         steer_d = steer_map(bits_nxt_c, steer_q);
         unique case (state_q)
            FOLLOW: begin
               if (bits_nxt_c == 3'b111) begin
                  lost_deb_d = '0;
                  if (node_deb_q == DEB_W'(NODE_DEB - 1)) begin
                     state_d      = NODE;
                     node_deb_d   = '0;
                     node_pulse_d = 1'b1;
                  end else begin
                     node_deb_d = node_deb_q + DEB_W'(1);
                  end
               end else if (bits_nxt_c == 3'b000) begin
                  node_deb_d = '0;
                  if (lost_deb_q == DEB_W'(LOST_DEB - 1)) begin
                     state_d    = LOST;
                     lost_deb_d = '0;
                  end else begin
                     lost_deb_d = lost_deb_q + DEB_W'(1);
                  end
               end else begin
                  node_deb_d = '0;
                  lost_deb_d = '0;
               end
            end
            NODE: begin
               // node_deb doubles as the exit counter while in NODE
               if (bits_nxt_c == 3'b111) begin
                  node_deb_d = '0;
               end else if (node_deb_q == DEB_W'(NODE_DEB - 1)) begin
                  state_d    = FOLLOW;
                  node_deb_d = '0;
               end else begin
                  node_deb_d = node_deb_q + DEB_W'(1);
               end
            end
            LOST: begin
               if (bits_nxt_c != 3'b000) begin
                  state_d = FOLLOW;
               end
            end
            default: begin
               state_d    = FOLLOW;
               node_deb_d = '0;
               lost_deb_d = '0;
            end
         endcase
      end

      // A clear coinciding with a node entry counts that node.
      if (node_clr) begin
         count_d = node_pulse_d ? CNT_W'(1) : '0;
      end else if (node_pulse_d && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Pipeline valids, FSM state and output registers.
   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         s1_valid_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         state_q      <= FOLLOW;
         node_deb_q   <= '0;
         lost_deb_q   <= '0;
         steer_q      <= STEER_CTR;
         node_pulse_q <= 1'b0;
         count_q      <= '0;
      end else begin
         s1_valid_q   <= sample_valid;
         out_valid_q  <= s1_valid_q;
         state_q      <= state_d;
         node_deb_q   <= node_deb_d;
         lost_deb_q   <= lost_deb_d;
         steer_q      <= steer_d;
         node_pulse_q <= node_pulse_d;
         count_q      <= count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign steer_err  = steer_q;
   assign node_pulse = node_pulse_q;
   assign node_count = count_q;
   assign line_lost  = (state_q == LOST);

endmodule
